t_flip_flop: RTL and testbench

T_FLIP_FLOP -- requirements
Module: t_flip_flop

---
 rtl/t_flip_flop.sv | 50 +++++
 tb/tb_t_flip_flop.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/t_flip_flop.sv
// Bank of WIDTH independent synchronous toggle flip-flops with reset > set > toggle priority.
// Optional saturating toggle-event counter when TFF_TOGGLE_COUNT_EN is defined.
module t_flip_flop #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
`ifdef TFF_TOGGLE_COUNT_EN
  ,
  output logic [CNT_W-1:0] toggle_cnt
`endif
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("t_flip_flop: WIDTH out of range 1..64");
  end
  if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
    $error("t_flip_flop: CNT_W out of range 2..32");
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (set) begin
      q <= '1;
    end else begin
      q <= q ^ t;
    end
  end

  // Complement is taken straight from the register so it tracks q even while in reset.
  assign qb = ~q;

`ifdef TFF_TOGGLE_COUNT_EN
  // Counts edges where at least one bit toggled; a preset edge is not a toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      toggle_cnt <= '0;
    end else if (!set && (|t) && (toggle_cnt != {CNT_W{1'b1}})) begin
      toggle_cnt <= toggle_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_t_flip_flop.sv
// Directed bench for t_flip_flop: a 1-bit and a 4-bit instance, both built with CNT_W=2.
// Counter checks are compiled in only when TFF_TOGGLE_COUNT_EN is defined.
module tb_t_flip_flop;

  logic       clk;
  logic       reset1, set1, t1, q1, qb1;
  logic       reset4, set4;
  logic [3:0] t4, q4, qb4;
`ifdef TFF_TOGGLE_COUNT_EN
  logic [1:0] cnt1, cnt4;
`endif

  int tests_run;
  int tests_failed;
  logic [3:0] exp_q[$];
  logic [3:0] exp_v;

  t_flip_flop #(.WIDTH(1), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset1), .set(set1), .t(t1), .q(q1), .qb(qb1)
`ifdef TFF_TOGGLE_COUNT_EN
    , .toggle_cnt(cnt1)
`endif
  );

  t_flip_flop #(.WIDTH(4), .CNT_W(2)) dut4 (
    .clk(clk), .reset(reset4), .set(set4), .t(t4), .q(q4), .qb(qb4)
`ifdef TFF_TOGGLE_COUNT_EN
    , .toggle_cnt(cnt4)
`endif
  );

  // Clock block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive on the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic r1, input logic s1, input logic tv1,
                      input logic r4, input logic s4, input logic [3:0] tv4);
    @(negedge clk);
    reset1 = r1; set1 = s1; t1 = tv1;
    reset4 = r4; set4 = s4; t4 = tv4;
    @(posedge clk);
    #1;
  endtask

  task automatic step1(input logic r, input logic s, input logic tv);
    step(r, s, tv, 1'b0, 1'b0, 4'b0000);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic exp);
    chk({tag, ".q"}, {31'd0, q1}, {31'd0, exp});
    chk({tag, ".qb"}, {31'd0, qb1}, {31'd0, ~exp});
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    reset1 = 1'b0; set1 = 1'b0; t1 = 1'b0;
    reset4 = 1'b0; set4 = 1'b0; t4 = 4'b0000;

    // Reset wins over set and toggle on both instances.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1111);
    chk1("reset", 1'b0);
    chk("reset4.q", {28'd0, q4}, 32'h0);
    chk("reset4.qb", {28'd0, qb4}, 32'hf);
`ifdef TFF_TOGGLE_COUNT_EN
    chk("reset.cnt", {30'd0, cnt1}, 32'h0);
`endif

    // Toggle four times, then hold for three edges.
    exp_q.push_back(4'd1); exp_q.push_back(4'd0);
    exp_q.push_back(4'd1); exp_q.push_back(4'd0);
    for (int i = 0; i < 4; i++) begin
      step1(1'b0, 1'b0, 1'b1);
      exp_v = exp_q.pop_front();
      chk1($sformatf("toggle%0d", i), exp_v[0]);
    end
    for (int i = 0; i < 3; i++) begin
      step1(1'b0, 1'b0, 1'b0);
      chk1($sformatf("hold%0d", i), 1'b0);
    end

    // Set beats toggle on two consecutive edges, then toggling resumes.
    step1(1'b0, 1'b1, 1'b1);
    chk1("set0", 1'b1);
    step1(1'b0, 1'b1, 1'b1);
    chk1("set1", 1'b1);
    step1(1'b0, 1'b0, 1'b1);
    chk1("after_set", 1'b0);

    // Reset arriving with a pending toggle discards it.
    step1(1'b0, 1'b0, 1'b1);
    chk1("pre_mid_reset", 1'b1);
    step1(1'b1, 1'b0, 1'b1);
    chk1("mid_reset", 1'b0);
    step1(1'b0, 1'b0, 1'b1);
    chk1("post_mid_reset", 1'b1);

    // Multi-bit: independent per-bit toggles, then set and reset of the whole bank.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010);
    chk("mb0.q", {28'd0, q4}, 32'ha);
    chk("mb0.qb", {28'd0, qb4}, 32'h5);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0110);
    chk("mb1.q", {28'd0, q4}, 32'hc);
    chk("mb1.qb", {28'd0, qb4}, 32'h3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    chk("mb_hold.q", {28'd0, q4}, 32'hc);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0101);
    chk("mb_set.q", {28'd0, q4}, 32'hf);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1111);
    chk("mb_reset.q", {28'd0, q4}, 32'h0);
    chk("mb_reset.qb", {28'd0, qb4}, 32'hf);
    chk1("mb_untouched", 1'b1);

`ifdef TFF_TOGGLE_COUNT_EN
    // Counter saturates at 3, ignores set, clears on reset.
    step1(1'b1, 1'b0, 1'b0);
    chk("cnt_clr", {30'd0, cnt1}, 32'h0);
    exp_q.push_back(4'd1); exp_q.push_back(4'd2); exp_q.push_back(4'd3);
    exp_q.push_back(4'd3); exp_q.push_back(4'd3);
    for (int i = 0; i < 5; i++) begin
      step1(1'b0, 1'b0, 1'b1);
      exp_v = exp_q.pop_front();
      chk($sformatf("cnt%0d", i), {30'd0, cnt1}, {28'd0, exp_v});
    end
    chk1("cnt_q", 1'b1);
    step1(1'b0, 1'b1, 1'b1);
    chk("cnt_set", {30'd0, cnt1}, 32'h3);
    step1(1'b1, 1'b0, 1'b1);
    chk("cnt_reset", {30'd0, cnt1}, 32'h0);
    chk1("cnt_reset_q", 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
